// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C receive sequencer.
//   i2c_state_t   : sequencer FSM state encoding
//   I2C_BYTE_BITS : bits per received byte
//   I2C_ACK/NACK  : sda_oe level driven in the ACK slot (1 = pull SDA low)
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT  = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } i2c_state_t;

    localparam int   I2C_BYTE_BITS = 8;
    localparam logic I2C_ACK       = 1'b1;
    localparam logic I2C_NACK      = 1'b0;

endpackage

// File: rtl/i2c_rx_shift.sv
// MSB-first receive shift register with bit counter.
//   clk, rst  : clock, async active-high reset
//   shift_en  : shift bit_in in and advance the bit counter
//   clear     : restart the bit counter (priority over shift_en)
//   bit_in    : sampled SDA level
//   rx_byte   : byte formed by the held bits plus bit_in
//   byte_full : seven bits held, so the next shift completes the byte
module i2c_rx_shift
    import i2c_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en,
    input  logic                     clear,
    input  logic                     bit_in,
    output logic [I2C_BYTE_BITS-1:0] rx_byte,
    output logic                     byte_full
);

    // Only seven bits are stored; the eighth arrives on bit_in and is
    // captured straight into the consumer's data register.
    logic [I2C_BYTE_BITS-2:0] sreg;
    logic [2:0]               bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sreg    <= rx_byte[I2C_BYTE_BITS-2:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign rx_byte   = {sreg, bit_in};
    assign byte_full = (bit_cnt == 3'(I2C_BYTE_BITS - 1));

endmodule

// File: rtl/i2c_rx_sequencer.sv
// I2C read-burst sequencer: receives burst x size bytes MSB-first on SCL
// rising edges, strobes the RX bit counter per bit, drives ACK/NACK and
// hands each byte downstream over valid/ready.
//   clk, rst            : clock, async active-high reset
//   start, burst, size  : burst request and its counts (latched in IDLE)
//   abort               : synchronous return to IDLE, highest priority
//   scl_rise, scl_fall  : SCL edge strobes; sda_in : synchronized SDA
//   sda_oe              : 1 = pull SDA low (ACK)
//   dec_rx_count        : one strobe per received bit
//   rx_data/valid/ready : downstream byte handshake
//   busy, done, overrun : status (overrun sticky until next accepted start)
//
// state   | meaning
// IDLE    | waiting for start with non-zero counts
// BIT     | sampling data bits on scl_rise
// ACK     | first scl_fall drives ACK/NACK, second ends the slot
// DONE    | one-cycle done pulse, then IDLE
module i2c_rx_sequencer
    import i2c_pkg::*;
#(
    parameter int BURST_W = 7,
    parameter int SIZE_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [BURST_W-1:0]       burst,
    input  logic [SIZE_W-1:0]        size,
    input  logic                     scl_rise,
    input  logic                     scl_fall,
    input  logic                     sda_in,
    output logic                     sda_oe,
    output logic                     dec_rx_count,
    output logic [I2C_BYTE_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    i2c_state_t               state_q, state_n;
    logic [BURST_W-1:0]       burst_left, burst_left_n;
    logic [SIZE_W-1:0]        byte_left, byte_left_n;
    logic [SIZE_W-1:0]        size_lat, size_lat_n;
    logic                     ack_half, ack_half_n;
    logic                     sda_oe_n, dec_n, rx_valid_n, busy_n, done_n, overrun_n;
    logic [I2C_BYTE_BITS-1:0] rx_data_n;
    logic                     shift_en, shift_clr;
    logic [I2C_BYTE_BITS-1:0] rx_byte;
    logic                     byte_full;
    logic                     rise_q, fall_q, last_byte;

    // Coincident edges are treated as noise.
    assign rise_q    = scl_rise & ~scl_fall;
    assign fall_q    = scl_fall & ~scl_rise;
    assign last_byte = (byte_left == SIZE_W'(1)) && (burst_left == BURST_W'(1));

    i2c_rx_shift u_shift (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (shift_en),
        .clear     (shift_clr),
        .bit_in    (sda_in),
        .rx_byte   (rx_byte),
        .byte_full (byte_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            burst_left   <= '0;
            byte_left    <= '0;
            size_lat     <= '0;
            ack_half     <= 1'b0;
            sda_oe       <= 1'b0;
            dec_rx_count <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_n;
            burst_left   <= burst_left_n;
            byte_left    <= byte_left_n;
            size_lat     <= size_lat_n;
            ack_half     <= ack_half_n;
            sda_oe       <= sda_oe_n;
            dec_rx_count <= dec_n;
            rx_data      <= rx_data_n;
            rx_valid     <= rx_valid_n;
            busy         <= busy_n;
            done         <= done_n;
            overrun      <= overrun_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        burst_left_n = burst_left;
        byte_left_n  = byte_left;
        size_lat_n   = size_lat;
        ack_half_n   = ack_half;
        sda_oe_n     = sda_oe;
        rx_data_n    = rx_data;
        overrun_n    = overrun;
        dec_n        = 1'b0;
        done_n       = 1'b0;
        shift_en     = 1'b0;
        shift_clr    = 1'b0;
        // Handshake runs in every state, so a byte survives abort and
        // a completing handshake frees the slot for a same-cycle load.
        rx_valid_n   = rx_valid & ~rx_ready;

        if (abort) begin
            state_n    = ST_IDLE;
            sda_oe_n   = I2C_NACK;
            ack_half_n = 1'b0;
            shift_clr  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && (burst != '0) && (size != '0)) begin
                        burst_left_n = burst;
                        byte_left_n  = size;
                        size_lat_n   = size;
                        overrun_n    = 1'b0;
                        ack_half_n   = 1'b0;
                        shift_clr    = 1'b1;
                        state_n      = ST_BIT;
                    end
                end
                ST_BIT: begin
                    if (rise_q) begin
                        shift_en = 1'b1;
                        dec_n    = 1'b1;
                        if (byte_full) begin
                            if (!rx_valid_n) begin
                                rx_data_n  = rx_byte;
                                rx_valid_n = 1'b1;
                            end else begin
                                overrun_n = 1'b1;
                            end
                            ack_half_n = 1'b0;
                            state_n    = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (fall_q) begin
                        if (!ack_half) begin
                            ack_half_n = 1'b1;
                            sda_oe_n   = last_byte ? I2C_NACK : I2C_ACK;
                        end else begin
                            ack_half_n = 1'b0;
                            sda_oe_n   = I2C_NACK;
                            shift_clr  = 1'b1;
                            if (byte_left != SIZE_W'(1)) begin
                                byte_left_n = byte_left - SIZE_W'(1);
                                state_n     = ST_BIT;
                            end else if (burst_left != BURST_W'(1)) begin
                                burst_left_n = burst_left - BURST_W'(1);
                                byte_left_n  = size_lat;
                                state_n      = ST_BIT;
                            end else begin
                                done_n  = 1'b1;
                                state_n = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_i2c_rx_sequencer.sv
module tb_i2c_rx_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [6:0] b_in;
    logic [3:0] s_in;
    logic       scl_rise, scl_fall, sda_in;
    logic       sda_oe, dec_rx_count;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, busy, done, overrun;

    i2c_rx_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .burst        (b_in),
        .size         (s_in),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .sda_in       (sda_in),
        .sda_oe       (sda_oe),
        .dec_rx_count (dec_rx_count),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_dec = 0;
    int n_done = 0;
    logic [7:0] hs_q[$];
    logic [7:0] tx_q[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (dec_rx_count) n_dec++;
            if (done) n_done++;
            if (rx_valid && rx_ready) hs_q.push_back(rx_data);
        end
    end

    typedef struct {
        int         b;
        int         s;
        logic       rdy;
        logic [7:0] base;
        int         exp_dec;
        bit         exp_done;
        bit         exp_ovr;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input bit noise);
        int n = noise ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                scl_rise = 1'b1;
                scl_fall = 1'b1;
            end
            tick();
            scl_rise = 1'b0;
            scl_fall = 1'b0;
        end
    endtask

    // Sends the top nbits of b; with nbits=8 the last fall opens the ACK slot.
    task automatic send_bits(input logic [7:0] b, input int nbits, input logic exp_ack, input bit noise);
        for (int i = 7; i >= 8 - nbits; i--) begin
            sda_in = b[i];
            gap(noise);
            scl_rise = 1'b1; tick(); scl_rise = 1'b0;
            gap(noise);
            scl_fall = 1'b1; tick(); scl_fall = 1'b0;
            if (i == 0) chk("ack_slot", sda_oe, exp_ack);
        end
    endtask

    task automatic ack_end(input bit noise);
        gap(noise);
        scl_rise = 1'b1; tick(); scl_rise = 1'b0;
        gap(noise);
        scl_fall = 1'b1; tick(); scl_fall = 1'b0;
        chk("ack_release", sda_oe, 0);
    endtask

    task automatic pulse_start(input int b, input int s);
        b_in = 7'(b);
        s_in = 4'(s);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_burst(input int b, input int s, input logic rdy, input bit noise,
                             input int exp_dec, input bit exp_done, input bit exp_ovr);
        int  dec0 = n_dec;
        int  done0 = n_done;
        int  idx = 0;
        bit  accepted = (b != 0) && (s != 0);
        hs_q.delete();
        rx_ready = rdy;
        pulse_start(b, s);
        chk("busy_after_start", busy, accepted);
        if (accepted) begin
            for (int t = 0; t < b; t++) begin
                for (int k = 0; k < s; k++) begin
                    send_bits(tx_q[idx], 8, !((t == b - 1) && (k == s - 1)), noise);
                    ack_end(noise);
                    idx++;
                end
            end
        end
        for (int c = 0; c < 20 && busy; c++) tick();
        chk("busy_fall", busy, 0);
        tick();
        tick();
        chk("dec_count", n_dec - dec0, exp_dec);
        chk("done_count", n_done - done0, exp_done);
        chk("overrun", overrun, exp_ovr);
        if (rdy) begin
            chk("hs_count", hs_q.size(), accepted ? b * s : 0);
            for (int i = 0; i < hs_q.size() && i < tx_q.size(); i++)
                chk("hs_data", hs_q[i], tx_q[i]);
            chk("valid_idle", rx_valid, 0);
        end else if (accepted) begin
            chk("held_valid", rx_valid, 1);
            chk("held_data", rx_data, tx_q[0]);
            rx_ready = 1'b1;
            tick();
            tick();
            rx_ready = 1'b0;
            chk("drain_count", hs_q.size(), 1);
            if (hs_q.size() > 0) chk("drain_data", hs_q[0], tx_q[0]);
            chk("drain_valid", rx_valid, 0);
        end
    endtask

    task automatic fill_tx(input int nbytes, input logic [7:0] base);
        tx_q.delete();
        for (int k = 0; k < nbytes; k++) tx_q.push_back(base + 8'(k));
    endtask

    initial begin
        int dec0, done0, b, s;
        logic rdy;

        // Rows with ready=0 leave overrun set, so ignored-start rows follow ready=1 rows.
        tbl[0] = '{1, 1, 1'b1, 8'hA5,  8, 1'b1, 1'b0};
        tbl[1] = '{2, 2, 1'b1, 8'h01, 32, 1'b1, 1'b0};
        tbl[2] = '{1, 2, 1'b0, 8'hC3, 16, 1'b1, 1'b1};
        tbl[3] = '{3, 1, 1'b1, 8'h10, 24, 1'b1, 1'b0};
        tbl[4] = '{0, 3, 1'b1, 8'h00,  0, 1'b0, 1'b0};
        tbl[5] = '{3, 0, 1'b1, 8'h00,  0, 1'b0, 1'b0};
        tbl[6] = '{1, 3, 1'b0, 8'h70, 24, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; b_in = '0; s_in = '0;
        scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b0; rx_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_dec", dec_rx_count, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);

        foreach (tbl[i]) begin
            fill_tx(tbl[i].b * tbl[i].s, tbl[i].base);
            run_burst(tbl[i].b, tbl[i].s, tbl[i].rdy, 1'b0,
                      tbl[i].exp_dec, tbl[i].exp_done, tbl[i].exp_ovr);
        end

        // Abort after 5 bits of byte 2: first byte kept, no done.
        tx_q.delete(); tx_q.push_back(8'h3C); tx_q.push_back(8'h99);
        rx_ready = 1'b0;
        dec0 = n_dec; done0 = n_done;
        pulse_start(1, 2);
        send_bits(8'h3C, 8, 1'b1, 1'b0);
        ack_end(1'b0);
        send_bits(8'h99, 5, 1'b0, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sda_oe", sda_oe, 0);
        chk("abort_valid", rx_valid, 1);
        chk("abort_data", rx_data, 8'h3C);
        tick(); tick(); tick();
        chk("abort_dec", n_dec - dec0, 13);
        chk("abort_done", n_done - done0, 0);
        chk("abort_overrun", overrun, 0);
        rx_ready = 1'b1; tick(); tick();

        // Abort while ACK is being driven releases SDA.
        pulse_start(1, 2);
        send_bits(8'h55, 8, 1'b1, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_ack_sda_oe", sda_oe, 0);
        chk("abort_ack_busy", busy, 0);
        tick(); tick();
        fill_tx(1, 8'hA5);
        run_burst(1, 1, 1'b1, 1'b0, 8, 1'b1, 1'b0);

        // Asynchronous reset during the ACK slot.
        rx_ready = 1'b0;
        pulse_start(1, 2);
        send_bits(8'h81, 8, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sda_oe", sda_oe, 0);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_overrun", overrun, 0);
        tick();
        rst = 1'b0;
        tick();
        fill_tx(0, 8'h00);
        run_burst(0, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Randomized bursts with gaps and coincident-edge noise.
        for (int it = 0; it < 16; it++) begin
            b = int'($urandom_range(1, 3));
            s = int'($urandom_range(1, 3));
            rdy = 1'($urandom_range(0, 1));
            tx_q.delete();
            for (int k = 0; k < b * s; k++) tx_q.push_back(8'($urandom));
            run_burst(b, s, rdy, 1'b1, 8 * b * s, 1'b1, (!rdy) && (b * s > 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
